// File: rtl/msc_note_sequencer.sv
// Score ROM note sequencer driving the tone generator; MSC_LOOP_EN makes END restart the score instead of finishing.
// Tone starts 3 edges after play is sampled, and there is no backpressure: stop aborts to IDLE on the next edge.
module msc_note_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int BEAT_DIV = 1000000,
    parameter int GAP_CYC  = 40000
) (
    input  logic              C4m,
    input  logic              Re,
    input  logic              play,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              tone_en,
    output logic [13:0]       tone_div,
    output logic              note_strobe,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam int PW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(BEAT_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                tone_en_q, tone_en_d;
    logic [13:0]         div_q, div_d;
    logic                strobe_q, strobe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [2:0]          beat_q, beat_d;
    logic [2:0]          len_q, len_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [4:0]          code;

    assign code = rom_data[7:3];

    // Equal-tempered half-periods from C4 upward, in 4 MHz cycles.
    function automatic logic [13:0] note_div(input logic [4:0] c);
        case (c)
            5'd1:    note_div = 14'd7645;
            5'd2:    note_div = 14'd7215;
            5'd3:    note_div = 14'd6810;
            5'd4:    note_div = 14'd6428;
            5'd5:    note_div = 14'd6067;
            5'd6:    note_div = 14'd5727;
            5'd7:    note_div = 14'd5405;
            5'd8:    note_div = 14'd5102;
            5'd9:    note_div = 14'd4816;
            5'd10:   note_div = 14'd4545;
            5'd11:   note_div = 14'd4290;
            5'd12:   note_div = 14'd4050;
            5'd13:   note_div = 14'd3822;
            5'd14:   note_div = 14'd3608;
            5'd15:   note_div = 14'd3405;
            5'd16:   note_div = 14'd3214;
            5'd17:   note_div = 14'd3034;
            5'd18:   note_div = 14'd2863;
            5'd19:   note_div = 14'd2703;
            5'd20:   note_div = 14'd2551;
            5'd21:   note_div = 14'd2408;
            5'd22:   note_div = 14'd2273;
            5'd23:   note_div = 14'd2145;
            5'd24:   note_div = 14'd2025;
            5'd25:   note_div = 14'd1911;
            5'd26:   note_div = 14'd1804;
            5'd27:   note_div = 14'd1703;
            5'd28:   note_div = 14'd1607;
            5'd29:   note_div = 14'd1517;
            5'd30:   note_div = 14'd1432;
            default: note_div = 14'd0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tone_en_d = tone_en_q;
        div_d     = div_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        presc_d   = presc_q;
        beat_d    = beat_q;
        len_d     = len_q;
        gap_d     = gap_q;

        if (stop && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            addr_d    = '0;
            tone_en_d = 1'b0;
            presc_d   = '0;
            beat_d    = '0;
            gap_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d = '0;
                    if (play && !stop) state_d = S_FETCH;
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    if (code == 5'd31) begin
                        done_d = 1'b1;
`ifdef MSC_LOOP_EN
                        addr_d  = '0;
                        state_d = S_FETCH;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d   = S_PLAY;
                        strobe_d  = 1'b1;
                        tone_en_d = (code != 5'd0);
                        if (code != 5'd0) div_d = note_div(code);
                        len_d     = rom_data[2:0];
                        presc_d   = '0;
                        beat_d    = '0;
                    end
                end
                S_PLAY: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (beat_q == len_q) begin
                            tone_en_d = 1'b0;
                            beat_d    = '0;
                            if (GAP_CYC == 0) begin
                                addr_d  = addr_q + ADDR_W'(1);
                                state_d = S_FETCH;
                            end else begin
                                gap_d   = '0;
                                state_d = S_GAP;
                            end
                        end else begin
                            beat_d = beat_q + 3'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                S_DONE: begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    addr_d    = '0;
                    tone_en_d = 1'b0;
                    state_d   = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge C4m or negedge Re) begin
        if (!Re) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            tone_en_q <= 1'b0;
            div_q     <= '0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            presc_q   <= '0;
            beat_q    <= '0;
            len_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tone_en_q <= tone_en_d;
            div_q     <= div_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            presc_q   <= presc_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
        end
    end

    assign rom_addr    = addr_q;
    assign tone_en     = tone_en_q;
    assign tone_div    = div_q;
    assign note_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
